// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - request/response and SRAM pin bundle for the data-memory controller
interface sram_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  // Controller side: consumes requests and SRAM read data, drives everything else.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );

  // Requester/SRAM side: the mirror image of the controller.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - load/store sequencer for the word-wide data SRAM with sub-word RMW
module sram_access_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  sram_access_ctrl_if.slave bus
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_RESP} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_we;
  logic           r_signed;
  logic [1:0]     r_size;
  logic [1:0]     r_lane;
  logic [15:0]    r_wdata;

  logic           w_misaligned;
  logic [4:0]     w_shift;
  logic [31:0]    w_lane;
  logic [31:0]    w_ext;
  logic [31:0]    w_mask;
  logic [31:0]    w_ins;
  logic [31:0]    w_merged;

  assign bus.req_ready = (r_state == S_IDLE) && !reset;

  // Half needs even address, word (size 1x) needs a word-aligned address.
  assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  // Bit offset of the addressed lane inside the SRAM word, mirrored for big-endian.
  always_comb begin
    w_shift = 5'd0;
    if (r_size == 2'b00) begin
      w_shift = BIG_ENDIAN ? {~r_lane, 3'b000} : {r_lane, 3'b000};
    end else if (r_size == 2'b01) begin
      w_shift = BIG_ENDIAN ? {~r_lane[1], 4'b0000} : {r_lane[1], 4'b0000};
    end
  end

  // Load extraction and store merge, both working on the word currently read from SRAM.
  always_comb begin
    w_lane = bus.sram_dout >> w_shift;
    w_ext  = bus.sram_dout;
    w_mask = 32'h0000_FFFF;
    w_ins  = {16'h0000, r_wdata};
    case (r_size)
      2'b00: begin
        w_ext  = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
        w_mask = 32'h0000_00FF;
        w_ins  = {24'h000000, r_wdata[7:0]};
      end
      2'b01: w_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_ext = bus.sram_dout;
    endcase
    w_merged = (bus.sram_dout & ~(w_mask << w_shift)) | (w_ins << w_shift);
  end

  // Main sequencer: every strobe and response output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_signed      <= 1'b0;
      r_size        <= 2'b00;
      r_lane        <= 2'b00;
      r_wdata       <= 16'h0000;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.sram_cs   <= 1'b0;
      bus.sram_oe   <= 1'b0;
      bus.sram_we   <= 1'b0;
      bus.sram_addr <= 32'h0;
      bus.sram_din  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we          <= bus.req_we;
            r_signed      <= bus.req_signed;
            r_size        <= bus.req_size;
            r_lane        <= bus.req_addr[1:0];
            r_wdata       <= bus.req_wdata[15:0];
            bus.sram_addr <= {bus.req_addr[31:2], 2'b00};
            if (w_misaligned) begin
              r_state       <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'h0;
            end else if (bus.req_we && bus.req_size[1]) begin
              r_state      <= S_WR;
              r_cnt        <= RELOAD;
              bus.sram_din <= bus.req_wdata;
              bus.sram_cs  <= 1'b1;
              bus.sram_we  <= 1'b1;
            end else begin
              r_state     <= S_RD;
              r_cnt       <= RELOAD;
              bus.sram_cs <= 1'b1;
              bus.sram_oe <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (r_cnt == '0) begin
            bus.sram_cs <= 1'b0;
            bus.sram_oe <= 1'b0;
            if (r_we) begin
              r_state      <= S_GAP;
              bus.sram_din <= w_merged;
            end else begin
              r_state       <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_rdata <= w_ext;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          r_state     <= S_WR;
          r_cnt       <= RELOAD;
          bus.sram_cs <= 1'b1;
          bus.sram_we <= 1'b1;
        end
        S_WR: begin
          if (r_cnt == '0) begin
            r_state       <= S_RESP;
            bus.sram_cs   <= 1'b0;
            bus.sram_we   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state       <= S_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed and random load/store bench with an SRAM model and reference memory
module tb_sram_access_ctrl;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_access_ctrl_if bus();

  sram_access_ctrl #(.WAIT_CYCLES(W), .BIG_ENDIAN(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int total = 0;
  int bad   = 0;

  // SRAM model: asynchronous read, write on the clock while cs and we are high.
  assign bus.sram_dout = mem[bus.sram_addr[5:2]];
  always @(posedge clk) begin
    if (bus.sram_cs && bus.sram_we) mem[bus.sram_addr[5:2]] <= bus.sram_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input logic sgn, input logic [31:0] addr);
    longint unsigned v;
    int b;
    b = int'(addr[1:0]);
    case (size)
      2'd0: begin
        v = (word >> (8 * b)) % 256;
        if (sgn && v >= 128) v = v + 64'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (16 * (b / 2))) % 65536;
        if (sgn && v >= 32768) v = v + 64'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] bytes [4];
    int b;
    b = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    case (size)
      2'd0: bytes[b] = data[7:0];
      2'd1: begin
        bytes[2 * (b / 2)]     = data[7:0];
        bytes[2 * (b / 2) + 1] = data[15:8];
      end
      default: return data;
    endcase
    return {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

  // Issues one request (called at a negedge) and checks the cycle-by-cycle strobe timeline.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output int waited);
    logic [31:0] exp_rd, old;
    logic [2:0]  exp_s;
    int lat, l_exp, idx;
    bit err, sub;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    idx   = int'(addr[5:2]);
    err   = (size == 2'd1 && addr % 2 != 0) || (size >= 2'd2 && addr % 4 != 0);
    sub   = we && size < 2'd2;
    l_exp = err ? 1 : (sub ? 2 * W + 2 : W + 1);
    old   = ref_mem[idx];
    exp_rd = (err || we) ? 32'h0 : ref_load(old, size, sgn, addr);
    if (!err && we) ref_mem[idx] = ref_store(old, size, addr, wdata);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 2 * W + 4; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      exp_s = 3'b000;
      if (!err) begin
        if (!we)                 exp_s = 3'b110;
        else if (!sub)           exp_s = 3'b101;
        else if (k <= W)         exp_s = 3'b110;
        else if (k == W + 1)     exp_s = 3'b000;
        else                     exp_s = 3'b101;
      end
      check("strobes", {29'b0, bus.sram_cs, bus.sram_oe, bus.sram_we}, {29'b0, exp_s});
      check("ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.sram_cs === 1'b1) check("sram_addr", bus.sram_addr, {addr[31:2], 2'b00});
      if (bus.sram_we === 1'b1) check("sram_din", bus.sram_din, ref_mem[idx]);
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(l_exp));
    check("rsp_err", 32'(bus.rsp_err), 32'(err));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("resp_strobes", {29'b0, bus.sram_cs, bus.sram_oe, bus.sram_we}, 32'd0);
    check("ready_resp", 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    int w;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_strobes", {29'b0, bus.sram_cs, bus.sram_oe, bus.sram_we}, 32'd0);
    check("rst_sram_addr", bus.sram_addr, 32'd0);
    check("rst_sram_din", bus.sram_din, 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Fill the whole model memory through word stores.
    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0, w);

    // Word load of 0xDEADBEEF at 0x10.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, w);
    check("word_load_val", bus.rsp_rdata, 32'hDEADBEEF);

    // Byte loads at 0x13, signed and unsigned.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000, 1'b0, w);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, w);
    check("byte_load_s", bus.rsp_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, w);
    check("byte_load_u", bus.rsp_rdata, 32'h00000080);

    // Byte store read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, w);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 1'b0, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, w);
    check("byte_store_word", bus.rsp_rdata, 32'h1122AB44);

    // Misaligned word load.
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0, w);

    // Back-to-back loads with req_valid held high.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, w);
    check("b2b_wait", 32'(w), 32'd1);

    // Reset during the RD phase drops the transaction.
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h20; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("pre_rst_rd", {29'b0, bus.sram_cs, bus.sram_oe, bus.sram_we}, 32'd6);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_strobes", {29'b0, bus.sram_cs, bus.sram_oe, bus.sram_we}, 32'd0);
      check("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("ready_post_rst", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rsp_post_rst", 32'(bus.rsp_valid), 32'd0);
    end

    // Random traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, 1'b0, w);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
